// File: rtl/i2c_target.sv
// I2C target that maps bus writes and reads onto a simple 8-bit register port.
// Latency: SCL/SDA see SYNC_STAGES+1 cycles of input delay; SDA drive changes DATA_HOLD cycles after a detected SCL fall.
// Backpressure: none; SCL is never stretched, so rd_data_i must be valid the cycle after rd_en_o.
//
// Ports:
//   clk_i, rst_i           clock and synchronous active-high reset
//   scl_i, sda_i           raw bus inputs (asynchronous to clk_i)
//   sda_oe_o               1 pulls SDA low, 0 releases it
//   wr_en_o, wr_data_o     one-cycle register write strobe and its data
//   reg_addr_o             register pointer (auto-increments after each access)
//   rd_en_o, rd_data_i     one-cycle read request; data returned the next cycle
//   busy_o                 high between START and STOP
module i2c_target #(
  parameter logic [6:0] DEV_ADDR    = 7'h39,
  parameter int         DATA_HOLD   = 30,  // must be >= 1
  parameter int         SYNC_STAGES = 2    // must be >= 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe_o,
  output logic       wr_en_o,
  output logic [7:0] reg_addr_o,
  output logic [7:0] wr_data_o,
  output logic       rd_en_o,
  input  logic [7:0] rd_data_i,
  output logic       busy_o
);

  localparam int HW = (DATA_HOLD > 1) ? $clog2(DATA_HOLD) : 1;

  typedef enum logic [3:0] {
    ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_PTR, ST_PTR_ACK,
    ST_WR, ST_WR_ACK, ST_RD, ST_RD_ACK, ST_IGNORE
  } state_t;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_q, sda_q;
  logic                   scl_s, sda_s;
  logic                   scl_rise, scl_fall, start_det, stop_det;

  logic [2:0]    bit_cnt;
  logic [7:0]    rx_sr, tx_sr, rx_byte;
  logic          rd_ld;
  logic [HW-1:0] hold_cnt;
  logic          hold_act, oe_pend;

  logic ld_ptr, wr_fire, rd_fire, inc_ptr, cnt_clr, oe_sel, byte_end;

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  =  scl_s & ~scl_q;
  assign scl_fall  = ~scl_s &  scl_q;
  // SCL must be high on both samples so an SCL edge coinciding with an SDA
  // edge is never mistaken for a bus condition.
  assign start_det = scl_s & scl_q &  sda_q & ~sda_s;
  assign stop_det  = scl_s & scl_q & ~sda_q &  sda_s;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n  = state;
    ld_ptr   = 1'b0;
    wr_fire  = 1'b0;
    rd_fire  = 1'b0;
    inc_ptr  = 1'b0;
    cnt_clr  = 1'b0;
    rx_byte  = {rx_sr[6:0], sda_s};
    byte_end = (bit_cnt == 3'd7);

    // Value SDA takes after the hold delay following an SCL fall. ACK states
    // are entered on the 8th rise, so their fall is the one opening the ACK slot.
    case (state)
      ST_ADDR_ACK, ST_PTR_ACK, ST_WR_ACK: oe_sel = 1'b1;
      ST_RD:                              oe_sel = ~tx_sr[7];
      default:                            oe_sel = 1'b0;
    endcase

    if (stop_det) begin
      state_n = ST_IDLE;
      cnt_clr = 1'b1;
    end else if (start_det) begin
      state_n = ST_ADDR;
      cnt_clr = 1'b1;
    end else if (scl_rise) begin
      case (state)
        ST_ADDR: if (byte_end)
          state_n = (rx_byte[7:1] == DEV_ADDR) ? ST_ADDR_ACK : ST_IGNORE;
        ST_PTR: if (byte_end) begin
          ld_ptr  = 1'b1;
          state_n = ST_PTR_ACK;
        end
        ST_WR: if (byte_end) begin
          wr_fire = 1'b1;
          state_n = ST_WR_ACK;
        end
        ST_RD: if (byte_end) state_n = ST_RD_ACK;
        ST_ADDR_ACK: begin
          // rx_sr still holds the address byte; bit 0 is R/W.
          cnt_clr = 1'b1;
          if (rx_sr[0]) begin
            rd_fire = 1'b1;
            state_n = ST_RD;
          end else begin
            state_n = ST_PTR;
          end
        end
        ST_PTR_ACK, ST_WR_ACK: begin
          cnt_clr = 1'b1;
          state_n = ST_WR;
        end
        ST_RD_ACK: begin
          if (!sda_s) begin
            inc_ptr = 1'b1;
            rd_fire = 1'b1;
            cnt_clr = 1'b1;
            state_n = ST_RD;
          end else begin
            state_n = ST_IGNORE;
          end
        end
        default: state_n = state;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scl_sync   <= '1;
      sda_sync   <= '1;
      scl_q      <= 1'b1;
      sda_q      <= 1'b1;
      bit_cnt    <= 3'd0;
      rx_sr      <= 8'h00;
      tx_sr      <= 8'h00;
      rd_ld      <= 1'b0;
      wr_en_o    <= 1'b0;
      rd_en_o    <= 1'b0;
      wr_data_o  <= 8'h00;
      reg_addr_o <= 8'h00;
      busy_o     <= 1'b0;
      sda_oe_o   <= 1'b0;
      hold_act   <= 1'b0;
      hold_cnt   <= '0;
      oe_pend    <= 1'b0;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_q    <= scl_s;
      sda_q    <= sda_s;

      wr_en_o <= wr_fire;
      rd_en_o <= rd_fire;
      rd_ld   <= rd_en_o;

      if (scl_rise) rx_sr <= rx_byte;

      if (cnt_clr)
        bit_cnt <= 3'd0;
      else if (scl_rise && (state == ST_ADDR || state == ST_PTR ||
                            state == ST_WR   || state == ST_RD))
        bit_cnt <= bit_cnt + 3'd1;

      if (rd_ld)
        tx_sr <= rd_data_i;
      else if (scl_rise && state == ST_RD)
        tx_sr <= {tx_sr[6:0], 1'b0};

      if (wr_fire) wr_data_o <= rx_byte;

      // Pointer advances the cycle after a write strobe, or together with the
      // read request that follows a controller ACK.
      if (ld_ptr)
        reg_addr_o <= rx_byte;
      else if (wr_en_o || inc_ptr)
        reg_addr_o <= reg_addr_o + 8'd1;

      if (stop_det)       busy_o <= 1'b0;
      else if (start_det) busy_o <= 1'b1;

      // SDA only moves DATA_HOLD cycles after SCL falls, so it is stable
      // whenever SCL is high; STOP releases immediately.
      if (stop_det) begin
        sda_oe_o <= 1'b0;
        hold_act <= 1'b0;
      end else if (start_det) begin
        hold_act <= 1'b0;
      end else if (scl_fall) begin
        hold_act <= 1'b1;
        hold_cnt <= HW'(DATA_HOLD - 1);
        oe_pend  <= oe_sel;
      end else if (hold_act) begin
        if (hold_cnt == '0) begin
          sda_oe_o <= oe_pend;
          hold_act <= 1'b0;
        end else begin
          hold_cnt <= hold_cnt - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: bit-banged controller on an open-drain SDA.
module tb_i2c_target;

  localparam int HP = 50;  // SCL half period in clk cycles

  logic       clk = 1'b0;
  logic       rst;
  logic       scl;
  logic       sda_c;
  logic       sda_oe_o, wr_en_o, rd_en_o, busy_o;
  logic [7:0] reg_addr_o, wr_data_o, rd_data_i;
  wire        sda_line = sda_c & ~sda_oe_o;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] wr_a[$];
  logic [7:0] wr_d[$];
  int         rd_cnt = 0;
  logic       oe_seen = 1'b0;

  i2c_target dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .scl_i      (scl),
    .sda_i      (sda_line),
    .sda_oe_o   (sda_oe_o),
    .wr_en_o    (wr_en_o),
    .reg_addr_o (reg_addr_o),
    .wr_data_o  (wr_data_o),
    .rd_en_o    (rd_en_o),
    .rd_data_i  (rd_data_i),
    .busy_o     (busy_o)
  );

  always #5 clk = ~clk;

  // Register file seen by reads.
  always_comb begin
    case (reg_addr_o)
      8'h05:   rd_data_i = 8'h5A;
      8'h06:   rd_data_i = 8'hC3;
      default: rd_data_i = 8'h00;
    endcase
  end

  always @(negedge clk) begin
    if (wr_en_o) begin
      wr_a.push_back(reg_addr_o);
      wr_d.push_back(wr_data_o);
    end
    if (rd_en_o)  rd_cnt = rd_cnt + 1;
    if (sda_oe_o) oe_seen = 1'b1;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic i2c_start();
    sda_c = 1'b1; cyc(HP);
    scl   = 1'b1; cyc(HP);
    sda_c = 1'b0; cyc(HP);
    scl   = 1'b0; cyc(5);
  endtask

  task automatic i2c_stop();
    sda_c = 1'b0; cyc(HP);
    scl   = 1'b1; cyc(HP);
    sda_c = 1'b1; cyc(HP);
  endtask

  task automatic bit_out(input logic b);
    sda_c = b;    cyc(HP);
    scl   = 1'b1; cyc(HP);
    scl   = 1'b0; cyc(5);
  endtask

  // early: target drive 10 cycles into the ACK slot (before DATA_HOLD expires).
  task automatic write_byte(input logic [7:0] b, output logic ack, output logic early);
    for (int i = 7; i >= 0; i--) bit_out(b[i]);
    sda_c = 1'b1; cyc(10);
    early = sda_oe_o;
    cyc(HP - 10);
    scl = 1'b1; cyc(HP / 2);
    ack = sda_line;
    cyc(HP / 2);
    scl = 1'b0; cyc(5);
  endtask

  task automatic read_byte(input logic ack_bit, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sda_c = 1'b1; cyc(HP);
      scl   = 1'b1; cyc(HP / 2);
      b[i]  = sda_line;
      cyc(HP / 2);
      scl   = 1'b0; cyc(5);
    end
    bit_out(ack_bit);
  endtask

  task automatic clear_logs();
    wr_a.delete();
    wr_d.delete();
    rd_cnt  = 0;
    oe_seen = 1'b0;
  endtask

  logic       ack, early;
  logic [7:0] rb;

  initial begin
    rst = 1'b1; scl = 1'b1; sda_c = 1'b1;
    cyc(5);
    chk("rst_sda_oe",   sda_oe_o,   0);
    chk("rst_wr_en",    wr_en_o,    0);
    chk("rst_rd_en",    rd_en_o,    0);
    chk("rst_busy",     busy_o,     0);
    chk("rst_reg_addr", reg_addr_o, 8'h00);
    chk("rst_wr_data",  wr_data_o,  8'h00);
    rst = 1'b0;
    cyc(10);

    // Write 0xAB, 0xCD starting at pointer 0x10.
    clear_logs();
    i2c_start();
    chk("t1_busy_after_start", busy_o, 1);
    write_byte(8'h72, ack, early);
    chk("t1_ack_hold_early", early, 0);
    chk("t1_ack_addr", ack, 0);
    write_byte(8'h10, ack, early);
    chk("t1_ack_ptr", ack, 0);
    write_byte(8'hAB, ack, early);
    chk("t1_ack_d0", ack, 0);
    write_byte(8'hCD, ack, early);
    chk("t1_ack_d1", ack, 0);
    i2c_stop();
    chk("t1_busy_after_stop", busy_o, 0);
    chk("t1_wr_count", wr_a.size(), 2);
    chk("t1_wr0_addr", wr_a[0], 8'h10);
    chk("t1_wr0_data", wr_d[0], 8'hAB);
    chk("t1_wr1_addr", wr_a[1], 8'h11);
    chk("t1_wr1_data", wr_d[1], 8'hCD);
    chk("t1_reg_addr", reg_addr_o, 8'h12);

    // Pointer 0x05, repeated START, read two bytes (ACK then NACK).
    clear_logs();
    i2c_start();
    write_byte(8'h72, ack, early);
    chk("t2_ack_addr_w", ack, 0);
    write_byte(8'h05, ack, early);
    chk("t2_ack_ptr", ack, 0);
    i2c_start();
    write_byte(8'h73, ack, early);
    chk("t2_ack_addr_r", ack, 0);
    read_byte(1'b0, rb);
    chk("t2_rd0", rb, 8'h5A);
    read_byte(1'b1, rb);
    chk("t2_rd1", rb, 8'hC3);
    i2c_stop();
    chk("t2_rd_en_count", rd_cnt, 2);
    chk("t2_wr_count", wr_a.size(), 0);
    chk("t2_reg_addr", reg_addr_o, 8'h06);
    chk("t2_sda_oe_idle", sda_oe_o, 0);

    // Foreign address 0x40: no ACK, no drive, no strobes.
    clear_logs();
    i2c_start();
    write_byte(8'h80, ack, early);
    chk("t3_nack_addr", ack, 1);
    write_byte(8'h55, ack, early);
    chk("t3_nack_data", ack, 1);
    i2c_stop();
    chk("t3_oe_never", oe_seen, 0);
    chk("t3_wr_count", wr_a.size(), 0);
    chk("t3_rd_count", rd_cnt, 0);

    // Pointer wrap 0xFF -> 0x00.
    clear_logs();
    i2c_start();
    write_byte(8'h72, ack, early);
    write_byte(8'hFF, ack, early);
    write_byte(8'h11, ack, early);
    write_byte(8'h22, ack, early);
    chk("t4_ack_last", ack, 0);
    i2c_stop();
    chk("t4_wr_count", wr_a.size(), 2);
    chk("t4_wr0_addr", wr_a[0], 8'hFF);
    chk("t4_wr0_data", wr_d[0], 8'h11);
    chk("t4_wr1_addr", wr_a[1], 8'h00);
    chk("t4_wr1_data", wr_d[1], 8'h22);
    chk("t4_reg_addr", reg_addr_o, 8'h01);

    // STOP after 4 data bits aborts the byte.
    clear_logs();
    i2c_start();
    write_byte(8'h72, ack, early);
    write_byte(8'h30, ack, early);
    bit_out(1'b1); bit_out(1'b0); bit_out(1'b1); bit_out(1'b0);
    i2c_stop();
    chk("t5_wr_count", wr_a.size(), 0);
    chk("t5_busy", busy_o, 0);
    chk("t5_sda_oe", sda_oe_o, 0);
    chk("t5_reg_addr", reg_addr_o, 8'h30);

    // Reset while the address ACK is being driven.
    clear_logs();
    i2c_start();
    for (int i = 7; i >= 0; i--) bit_out(1'((8'h72 >> i) & 8'h01));
    sda_c = 1'b1; cyc(45);
    chk("t6_ack_driven", sda_oe_o, 1);
    rst = 1'b1; cyc(1);
    chk("t6_oe_after_rst", sda_oe_o, 0);
    chk("t6_busy_after_rst", busy_o, 0);
    rst = 1'b0; cyc(5);
    scl = 1'b1; cyc(HP);
    scl = 1'b0; cyc(5);
    chk("t6_ignored_after_rst", sda_oe_o, 0);
    i2c_stop();
    i2c_start();
    write_byte(8'h72, ack, early);
    chk("t6_ack_addr", ack, 0);
    write_byte(8'h40, ack, early);
    write_byte(8'h99, ack, early);
    chk("t6_ack_data", ack, 0);
    i2c_stop();
    chk("t6_wr_count", wr_a.size(), 1);
    chk("t6_wr_addr", wr_a[0], 8'h40);
    chk("t6_wr_data", wr_d[0], 8'h99);
    chk("t6_reg_addr", reg_addr_o, 8'h41);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
